// File: rtl/zone_mean_calc_if.sv
// Pixel-in / means-out bundle for zone_mean_calc.
// The producer of the raster stream uses master; the mean calculator uses slave.
interface zone_mean_calc_if;
   logic             sof;
   logic             pix_vld;
   logic [7:0]       pix_r;
   logic [7:0]       pix_g;
   logic [7:0]       pix_b;
   logic [7:0][3:0]  MeanR;
   logic [7:0][3:0]  MeanG;
   logic [7:0][3:0]  MeanB;
   logic             start;
   logic             frm_err;

   modport master (
      output sof, pix_vld, pix_r, pix_g, pix_b,
      input  MeanR, MeanG, MeanB, start, frm_err
   );

   modport slave (
      input  sof, pix_vld, pix_r, pix_g, pix_b,
      output MeanR, MeanG, MeanB, start, frm_err
   );
endinterface

// File: rtl/zone_mean_calc.sv
// zone_mean_calc: accumulates R/G/B over a 4x2 grid of screen zones and
// publishes the top nibble of each zone's average with a one-cycle start pulse.
// Zone k covers x in [ (k%4)*ZW, (k%4+1)*ZW ), y in [ (k/4)*ZH, (k/4+1)*ZH ).
module zone_mean_calc #(
   parameter int IMG_W   = 64,
   parameter int IMG_H   = 32,
   parameter int ZW_LOG2 = 4,
   parameter int ZH_LOG2 = 4
) (
   input  logic             clk,
   input  logic             rstn,
   zone_mean_calc_if.slave  bus
);

   // Each zone holds 2^(ZW_LOG2+ZH_LOG2) pixels of 8 bits, so this width
   // can never overflow.
   localparam int ACC_W = 8 + ZW_LOG2 + ZH_LOG2;
   localparam int XW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int YW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int REG_W = 4 << ZW_LOG2;
   localparam int REG_H = 2 << ZH_LOG2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCUM   = 2'd1,
      PUBLISH = 2'd2
   } state_t;

   state_t           state;
   logic [XW-1:0]    x_cnt;
   logic [YW-1:0]    y_cnt;
   logic [XW-1:0]    cur_x;
   logic [YW-1:0]    cur_y;
   logic             in_reg;
   logic             last_reg;
   logic             frame_go;
   logic             add_en;
   logic [2:0]       zone;
   logic [ACC_W-1:0] acc_r [8];
   logic [ACC_W-1:0] acc_g [8];
   logic [ACC_W-1:0] acc_b [8];

   // Mean is the zone average truncated to its top nibble.
   function automatic logic [3:0] mean_nib(input logic [ACC_W-1:0] acc);
      return acc[ACC_W-1 -: 4];
   endfunction

   // Position of the pixel currently on the bus; sof overrides the counters.
   always_comb begin
      cur_x    = bus.sof ? '0 : x_cnt;
      cur_y    = bus.sof ? '0 : y_cnt;
      in_reg   = (int'(cur_x) < REG_W) && (int'(cur_y) < REG_H);
      last_reg = (int'(cur_x) == REG_W - 1) && (int'(cur_y) == REG_H - 1);
      zone     = {cur_y[ZH_LOG2], cur_x[ZW_LOG2+1:ZW_LOG2]};
      frame_go = bus.pix_vld & bus.sof;
      add_en   = (state == ACCUM) && bus.pix_vld && in_reg;
   end

   // Raster counters: advance one position per valid pixel.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         x_cnt <= '0;
         y_cnt <= '0;
      end else if (bus.pix_vld) begin
         if (int'(cur_x) == IMG_W - 1) begin
            x_cnt <= '0;
            y_cnt <= (int'(cur_y) == IMG_H - 1) ? '0 : cur_y + YW'(1);
         end else begin
            x_cnt <= cur_x + XW'(1);
            y_cnt <= cur_y;
         end
      end
   end

   // Accumulators: a new frame clears every zone and loads its first pixel.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int z = 0; z < 8; z++) begin
            acc_r[z] <= '0;
            acc_g[z] <= '0;
            acc_b[z] <= '0;
         end
      end else begin
         for (int z = 0; z < 8; z++) begin
            if (frame_go) begin
               acc_r[z] <= (zone == 3'(z)) ? ACC_W'(bus.pix_r) : '0;
               acc_g[z] <= (zone == 3'(z)) ? ACC_W'(bus.pix_g) : '0;
               acc_b[z] <= (zone == 3'(z)) ? ACC_W'(bus.pix_b) : '0;
            end else if (add_en && (zone == 3'(z))) begin
               acc_r[z] <= acc_r[z] + ACC_W'(bus.pix_r);
               acc_g[z] <= acc_g[z] + ACC_W'(bus.pix_g);
               acc_b[z] <= acc_b[z] + ACC_W'(bus.pix_b);
            end
         end
      end
   end

   // Frame FSM with registered start / frm_err pulses and mean registers.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state       <= IDLE;
         bus.start   <= 1'b0;
         bus.frm_err <= 1'b0;
         bus.MeanR   <= '0;
         bus.MeanG   <= '0;
         bus.MeanB   <= '0;
      end else begin
         bus.start   <= 1'b0;
         bus.frm_err <= 1'b0;
         case (state)
            IDLE: begin
               if (frame_go) state <= ACCUM;
            end
            ACCUM: begin
               if (frame_go) begin
                  // Frame restarted before completing: partial sums are dropped.
                  bus.frm_err <= 1'b1;
               end else if (bus.pix_vld && in_reg && last_reg) begin
                  state <= PUBLISH;
               end
            end
            PUBLISH: begin
               for (int z = 0; z < 8; z++) begin
                  bus.MeanR[z] <= mean_nib(acc_r[z]);
                  bus.MeanG[z] <= mean_nib(acc_g[z]);
                  bus.MeanB[z] <= mean_nib(acc_b[z]);
               end
               bus.start <= 1'b1;
               // A sof landing here is the first pixel of the next frame.
               state <= frame_go ? ACCUM : IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
